// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg
// Shared definitions for the instruction cycle sequencer: the sequencer
// state enum, the sub-phase enum and the maximum number of ck/stb steps
// an instruction may use.
package cycle_sequencer_pkg;

  // Largest supported number of ck/stb steps per instruction.
  localparam int STEPS_MAX = 6;

  // Width of the step counter k (holds 1..STEPS_MAX).
  localparam int K_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_FAULT
  } seq_state_t;

  // Each step has two cycles: A (ck only) and B (ck plus stb).
  typedef enum logic {
    PH_A,
    PH_B
  } phase_t;

endpackage : cycle_sequencer_pkg

// File: rtl/cycle_sequencer_phase_decode.sv
// seq_phase_decode
// Maps the registered sequencer state (state, step counter k, sub-phase)
// onto one-hot step-phase levels and register-clock strobes.
//
// Ports
//   state  in   sequencer state (only ST_EXEC produces any output)
//   k      in   current step number, 1..STEPS_MAX
//   phase  in   current sub-phase within the step
//   ck     out  ck[i] high for step i+1 in both phases
//   stb    out  stb[i] high for step i+1 in phase B only
module seq_phase_decode
  import cycle_sequencer_pkg::*;
(
  input  seq_state_t           state,
  input  logic [K_W-1:0]       k,
  input  phase_t               phase,
  output logic [STEPS_MAX-1:0] ck,
  output logic [STEPS_MAX-1:0] stb
);

  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    ck  = '0;
    stb = '0;
    if (state == ST_EXEC) begin
      for (int i = 0; i < STEPS_MAX; i++) begin
        if (k == K_W'(i + 1)) begin
          ck[i]  = 1'b1;
          stb[i] = (phase == PH_B);
        end
      end
    end
  end

endmodule : seq_phase_decode

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Instruction cycle sequencer. Steps the instruction decoders through up
// to STEPS ck/stb steps per instruction, two cycles per step (phase A: ck
// only, phase B: ck plus stb). The decoders end an instruction by raising
// done during a phase A; the strobe of that step is then never issued.
// Running past the last step without done is a sticky fault cleared only
// by reset. Every output is decoded from registered state, so no input
// reaches an output combinationally.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   level, continuous execution
//   step         in   pulse, execute exactly one instruction from idle
//   halt         in   level, stop at the next instruction boundary
//   done         in   OR of decoder done terms, sampled in phase A only
//   ck1..ck6     out  step-phase levels
//   stb1..stb6   out  register-clock strobes
//   instrStart   out  high in the first cycle of every instruction
//   running      out  high while an instruction is executing
//   timeout      out  sticky: no done within STEPS steps
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int STEPS = 6  // legal range 2..STEPS_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic halt,
  input  logic done,
  output logic ck1,
  output logic ck2,
  output logic ck3,
  output logic ck4,
  output logic ck5,
  output logic ck6,
  output logic stb1,
  output logic stb2,
  output logic stb3,
  output logic stb4,
  output logic stb5,
  output logic stb6,
  output logic instrStart,
  output logic running,
  output logic timeout
);

  localparam logic [K_W-1:0] FIRST_K = K_W'(1);
  localparam logic [K_W-1:0] LAST_K  = K_W'(STEPS);

  seq_state_t           state;
  logic [K_W-1:0]       k;
  phase_t               phase;
  // Set when the current instruction was launched by a step pulse; such an
  // instruction always returns to idle, whatever run says at its end.
  logic                 single;

  logic [STEPS_MAX-1:0] ck_vec;
  logic [STEPS_MAX-1:0] stb_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register is updated from the values present before the edge.
    if (!rst_n) begin
      state  <= ST_IDLE;
      k      <= FIRST_K;
      phase  <= PH_A;
      single <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // run wins over a simultaneous step pulse.
          if (run || step) begin
            state  <= ST_EXEC;
            k      <= FIRST_K;
            phase  <= PH_A;
            single <= !run;
          end
        end

        ST_EXEC: begin
          if (phase == PH_A) begin
            if (done) begin
              // Instruction boundary: the only place run/halt are honoured.
              k     <= FIRST_K;
              phase <= PH_A;
              if (!(run && !halt && !single)) begin
                state <= ST_IDLE;
              end
            end else begin
              phase <= PH_B;
            end
          end else if (k == LAST_K) begin
            state <= ST_FAULT;
            k     <= FIRST_K;
            phase <= PH_A;
          end else begin
            k     <= k + K_W'(1);
            phase <= PH_A;
          end
        end

        ST_FAULT: state <= ST_FAULT;

        default: begin
          state <= ST_IDLE;
          k     <= FIRST_K;
          phase <= PH_A;
        end
      endcase
    end
  end

  seq_phase_decode u_phase_decode (
    .state (state),
    .k     (k),
    .phase (phase),
    .ck    (ck_vec),
    .stb   (stb_vec)
  );

  assign {ck6, ck5, ck4, ck3, ck2, ck1}       = ck_vec;
  assign {stb6, stb5, stb4, stb3, stb2, stb1} = stb_vec;

  // Step 1 phase A is reached only at the start of an instruction.
  assign instrStart = (state == ST_EXEC) && (k == FIRST_K) && (phase == PH_A);
  assign running    = (state == ST_EXEC);
  assign timeout    = (state == ST_FAULT);

endmodule : cycle_sequencer

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
// Self-checking bench for cycle_sequencer (STEPS = 6). The reference model
// tracks an instruction as a running cycle index c: the active step is
// c/2+1, odd c carries the strobe, done counts only on even c, and reaching
// the end of the last step's strobe cycle is a timeout.
module tb_cycle_sequencer;

  localparam int STEPS = 6;

  logic clk = 1'b0;
  logic rst_n, run, step, halt, done;
  logic ck1, ck2, ck3, ck4, ck5, ck6;
  logic stb1, stb2, stb3, stb4, stb5, stb6;
  logic instrStart, running, timeout;

  int    tests = 0;
  int    fails = 0;
  string scen  = "init";

  // Reference model state.
  bit m_busy, m_fault, m_single;
  int m_cycle;

  always #5 clk = ~clk;

  cycle_sequencer #(.STEPS(STEPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .halt       (halt),
    .done       (done),
    .ck1        (ck1),
    .ck2        (ck2),
    .ck3        (ck3),
    .ck4        (ck4),
    .ck5        (ck5),
    .ck6        (ck6),
    .stb1       (stb1),
    .stb2       (stb2),
    .stb3       (stb3),
    .stb4       (stb4),
    .stb5       (stb5),
    .stb6       (stb6),
    .instrStart (instrStart),
    .running    (running),
    .timeout    (timeout)
  );

  function automatic logic [14:0] observed();
    return {timeout, running, instrStart,
            stb6, stb5, stb4, stb3, stb2, stb1,
            ck6, ck5, ck4, ck3, ck2, ck1};
  endfunction

  function automatic logic [14:0] expected();
    logic [5:0] c, s;
    c = '0;
    s = '0;
    if (m_busy) begin
      c[m_cycle / 2] = 1'b1;
      if (m_cycle % 2 == 1) s[m_cycle / 2] = 1'b1;
    end
    return {m_fault, m_busy, (m_busy && m_cycle == 0), s, c};
  endfunction

  function automatic void model_clear();
    m_busy   = 1'b0;
    m_fault  = 1'b0;
    m_single = 1'b0;
    m_cycle  = 0;
  endfunction

  // Advance the model by one rising edge with the inputs seen at that edge.
  function automatic void model_edge(input logic r, s, h, d);
    if (m_fault) return;
    if (!m_busy) begin
      if (r || s) begin
        m_busy   = 1'b1;
        m_cycle  = 0;
        m_single = !r;
      end
    end else if (m_cycle % 2 == 0 && d) begin
      if (r && !h && !m_single) m_cycle = 0;
      else m_busy = 1'b0;
    end else if (m_cycle == 2 * STEPS - 1) begin
      m_busy  = 1'b0;
      m_fault = 1'b1;
    end else begin
      m_cycle++;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", scen, tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle, take the edge, then compare 1 time unit later.
  task automatic tick(input logic r, s, h, d);
    run  = r;
    step = s;
    halt = h;
    done = d;
    @(posedge clk);
    model_edge(r, s, h, d);
    #1;
    check("cycle", 32'(observed()), 32'(expected()));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    halt  = 1'b0;
    done  = 1'b0;
    model_clear();
    #1;
    check("reset", 32'(observed()), 32'(expected()));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Done from a decoder that finishes in step n (raised in its phase A).
  function automatic logic done_at(input int n);
    return m_busy && (m_cycle == 2 * (n - 1));
  endfunction

  initial begin
    int starts, stb2_seen, run_cycles;
    logic r, s, h, d;
    int done_pct;

    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    halt  = 1'b0;
    done  = 1'b0;
    model_clear();

    // Continuous run, every instruction ends in step 2.
    scen = "run_step2";
    apply_reset();
    starts    = 0;
    stb2_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, done_at(2));
      starts    += int'(instrStart);
      stb2_seen += int'(stb2);
    end
    check("starts", 32'(starts), 32'd4);
    check("stb2", 32'(stb2_seen), 32'd0);

    // Single step, done in step 4.
    scen = "step_done4";
    apply_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycles = int'(running);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, done_at(4));
      run_cycles += int'(running);
    end
    check("run_cycles", 32'(run_cycles), 32'd7);

    // Halt raised during step 2 phase B, instruction ends in step 3.
    scen = "halt";
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    starts = int'(instrStart);
    while (m_busy) begin
      tick(1'b1, 1'b0, (m_busy && m_cycle >= 3), done_at(3));
      starts += int'(instrStart);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      starts += int'(instrStart);
    end
    check("starts", 32'(starts), 32'd1);

    // No done at all: six steps, then sticky timeout.
    scen = "timeout";
    apply_reset();
    for (int i = 0; i < 2 * STEPS + 1; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("timeout", 32'(timeout), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, i[0], i[1], 1'b1);
    apply_reset();
    check("cleared", 32'(timeout), 32'd0);

    // Asynchronous reset during the step 2 strobe, restart with run held.
    scen = "reset_mid";
    apply_reset();
    while (!(m_busy && m_cycle == 3)) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("in_stb2", 32'(stb2), 32'd1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_low", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_ck1", 32'(ck1), 32'd1);

    // Done high only in phase B is ignored; done in step 3 phase A ends it.
    scen = "done_phase_b";
    apply_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycles = int'(running);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, (m_busy && m_cycle % 2 == 1) || done_at(3));
      run_cycles += int'(running);
    end
    check("run_cycles", 32'(run_cycles), 32'd5);

    // Randomized traffic with varying done density and occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      scen = $sformatf("random%0d", blk);
      done_pct = 40 >> blk;
      apply_reset();
      for (int i = 0; i < 150; i++) begin
        r = ($urandom_range(99) < 60);
        s = ($urandom_range(99) < 15);
        h = ($urandom_range(99) < 20);
        d = ($urandom_range(99) < done_pct);
        tick(r, s, h, d);
        if ($urandom_range(99) < 2) begin
          #2;
          rst_n = 1'b0;
          model_clear();
          #1;
          check("async_rand", 32'(observed()), 32'(expected()));
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cycle_sequencer
